// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_port_arbiter
// Brief    : Arbitrates one data-memory port between LSQ loads and retired-
//            store drains. Two-state FSM (IDLE/WAIT) with a wait counter that
//            times out unanswered requests and raises a sticky error flag.
//            Optional macro MEM_ARB_RR_EN: alternate grants under contention
//            (first contention after reset goes to the load); when undefined,
//            loads have fixed priority.
// Revision : 1.0 - initial release
// ============================================================================
module mem_port_arbiter #(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int MAX_WAIT = 15
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              ld_req,
    input  logic [31:0]       ld_pc,
    input  logic [ADDR_W-1:0] ld_addr,
    output logic              ld_gnt,
    output logic              ld_done,
    output logic [31:0]       ld_done_pc,
    output logic [DATA_W-1:0] ld_data,
    input  logic              st_req,
    input  logic [ADDR_W-1:0] st_addr,
    input  logic [DATA_W-1:0] st_data,
    output logic              st_gnt,
    output logic              st_done,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy,
    output logic              timeout_err
);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } state_t;

    localparam logic [7:0] C_MAX_WAIT = 8'(MAX_WAIT);

    state_t              state_q,       state_d;
    logic [7:0]          wait_cnt_q,    wait_cnt_d;
    logic [31:0]         pc_lat_q,      pc_lat_d;
    logic                mem_req_q,     mem_req_d;
    logic                mem_we_q,      mem_we_d;
    logic [ADDR_W-1:0]   mem_addr_q,    mem_addr_d;
    logic [DATA_W-1:0]   mem_wdata_q,   mem_wdata_d;
    logic                ld_gnt_q,      ld_gnt_d;
    logic                st_gnt_q,      st_gnt_d;
    logic                ld_done_q,     ld_done_d;
    logic                st_done_q,     st_done_d;
    logic [DATA_W-1:0]   ld_data_q,     ld_data_d;
    logic [31:0]         ld_done_pc_q,  ld_done_pc_d;
    logic                timeout_err_q, timeout_err_d;
    logic                w_grant_ld;

`ifdef MEM_ARB_RR_EN
    // Set when the most recent contended grant went to the load.
    logic                last_ld_q,     last_ld_d;

    // Alternate under contention; a lone request always wins.
    always_comb begin
        w_grant_ld = ld_req && (!st_req || !last_ld_q);
        last_ld_d  = last_ld_q;
        if (state_q == ST_IDLE && ld_req && st_req) begin
            last_ld_d = w_grant_ld;
        end
    end

    // Last-grant history register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) last_ld_q <= 1'b0;
        else       last_ld_q <= last_ld_d;
    end
`else
    // Fixed priority: a pending load always beats a store.
    always_comb begin
        w_grant_ld = ld_req;
    end
`endif

    // Next-state and output logic; mem_we_q doubles as the owner flag (1 = store).
    always_comb begin
        state_d       = state_q;
        wait_cnt_d    = wait_cnt_q;
        pc_lat_d      = pc_lat_q;
        mem_req_d     = mem_req_q;
        mem_we_d      = mem_we_q;
        mem_addr_d    = mem_addr_q;
        mem_wdata_d   = mem_wdata_q;
        ld_gnt_d      = 1'b0;
        st_gnt_d      = 1'b0;
        ld_done_d     = 1'b0;
        st_done_d     = 1'b0;
        ld_data_d     = ld_data_q;
        ld_done_pc_d  = ld_done_pc_q;
        timeout_err_d = timeout_err_q;
        case (state_q)
            ST_IDLE: begin
                if (ld_req || st_req) begin
                    state_d    = ST_WAIT;
                    wait_cnt_d = 8'd0;
                    mem_req_d  = 1'b1;
                    if (w_grant_ld) begin
                        ld_gnt_d   = 1'b1;
                        mem_we_d   = 1'b0;
                        mem_addr_d = ld_addr;
                        pc_lat_d   = ld_pc;
                    end else begin
                        st_gnt_d    = 1'b1;
                        mem_we_d    = 1'b1;
                        mem_addr_d  = st_addr;
                        mem_wdata_d = st_data;
                    end
                end
            end
            ST_WAIT: begin
                if (mem_ack || wait_cnt_q == C_MAX_WAIT) begin
                    // An ack on the limit cycle still counts as a normal completion.
                    state_d   = ST_IDLE;
                    mem_req_d = 1'b0;
                    if (!mem_ack) begin
                        timeout_err_d = 1'b1;
                    end
                    if (!mem_we_q) begin
                        ld_done_d    = 1'b1;
                        ld_data_d    = mem_ack ? mem_rdata : '0;
                        ld_done_pc_d = pc_lat_q;
                    end else begin
                        st_done_d = 1'b1;
                    end
                end else begin
                    wait_cnt_d = wait_cnt_q + 8'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers with asynchronous clear.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q       <= ST_IDLE;
            wait_cnt_q    <= 8'd0;
            pc_lat_q      <= 32'd0;
            mem_req_q     <= 1'b0;
            mem_we_q      <= 1'b0;
            mem_addr_q    <= '0;
            mem_wdata_q   <= '0;
            ld_gnt_q      <= 1'b0;
            st_gnt_q      <= 1'b0;
            ld_done_q     <= 1'b0;
            st_done_q     <= 1'b0;
            ld_data_q     <= '0;
            ld_done_pc_q  <= 32'd0;
            timeout_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            wait_cnt_q    <= wait_cnt_d;
            pc_lat_q      <= pc_lat_d;
            mem_req_q     <= mem_req_d;
            mem_we_q      <= mem_we_d;
            mem_addr_q    <= mem_addr_d;
            mem_wdata_q   <= mem_wdata_d;
            ld_gnt_q      <= ld_gnt_d;
            st_gnt_q      <= st_gnt_d;
            ld_done_q     <= ld_done_d;
            st_done_q     <= st_done_d;
            ld_data_q     <= ld_data_d;
            ld_done_pc_q  <= ld_done_pc_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    assign ld_gnt      = ld_gnt_q;
    assign st_gnt      = st_gnt_q;
    assign ld_done     = ld_done_q;
    assign st_done     = st_done_q;
    assign ld_data     = ld_data_q;
    assign ld_done_pc  = ld_done_pc_q;
    assign mem_req     = mem_req_q;
    assign mem_we      = mem_we_q;
    assign mem_addr    = mem_addr_q;
    assign mem_wdata   = mem_wdata_q;
    assign busy        = (state_q != ST_IDLE);
    assign timeout_err = timeout_err_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_port_arbiter
// Brief    : Directed self-checking bench for mem_port_arbiter (MAX_WAIT=4).
//            Expectations for contention follow MEM_ARB_RR_EN when defined.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_port_arbiter;

    logic        clk;
    logic        rstn;
    logic        ld_req;
    logic [31:0] ld_pc;
    logic [31:0] ld_addr;
    logic        ld_gnt;
    logic        ld_done;
    logic [31:0] ld_done_pc;
    logic [31:0] ld_data;
    logic        st_req;
    logic [31:0] st_addr;
    logic [31:0] st_data;
    logic        st_gnt;
    logic        st_done;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic        busy;
    logic        timeout_err;

    int checks = 0;
    int errors = 0;

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_WAIT(4)) dut (
        .clk(clk), .rstn(rstn),
        .ld_req(ld_req), .ld_pc(ld_pc), .ld_addr(ld_addr),
        .ld_gnt(ld_gnt), .ld_done(ld_done), .ld_done_pc(ld_done_pc), .ld_data(ld_data),
        .st_req(st_req), .st_addr(st_addr), .st_data(st_data),
        .st_gnt(st_gnt), .st_done(st_done),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .busy(busy), .timeout_err(timeout_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rstn = 1'b1; ld_req = 0; st_req = 0; mem_ack = 0;
        ld_pc = 0; ld_addr = 0; st_addr = 0; st_data = 0; mem_rdata = 0;
        #2 rstn = 1'b0;
        #1;
        checks++;
        if ({ld_gnt, st_gnt, ld_done, st_done, mem_req, mem_we, busy, timeout_err} !== 8'h00 ||
            ld_data !== 32'h0 || ld_done_pc !== 32'h0 || mem_addr !== 32'h0 || mem_wdata !== 32'h0) begin
            errors++;
            $display("FAIL reset_values: flags=%b ld_data=%h pc=%h addr=%h wdata=%h, want all zero",
                     {ld_gnt, st_gnt, ld_done, st_done, mem_req, mem_we, busy, timeout_err},
                     ld_data, ld_done_pc, mem_addr, mem_wdata);
        end
        // A request during reset must not be granted.
        ld_req = 1'b1;
        tick();
        checks++;
        if (ld_gnt !== 1'b0 || mem_req !== 1'b0) begin
            errors++;
            $display("FAIL gnt_in_reset: ld_gnt=%b mem_req=%b, want 0 0", ld_gnt, mem_req);
        end
        ld_req = 1'b0;
        #3 rstn = 1'b1;
        // mem_ack while idle is ignored.
        tick();
        mem_ack = 1'b1; mem_rdata = 32'hAAAA_5555;
        tick();
        checks++;
        if (ld_done !== 1'b0 || st_done !== 1'b0 || busy !== 1'b0 || ld_data !== 32'h0) begin
            errors++;
            $display("FAIL idle_ack_ignored: ld_done=%b st_done=%b busy=%b ld_data=%h, want 0 0 0 0",
                     ld_done, st_done, busy, ld_data);
        end
        mem_ack = 1'b0; mem_rdata = 32'h0;
    endtask

    task automatic test_load();
        ld_req = 1'b1; ld_pc = 32'h8; ld_addr = 32'h100;
        tick();
        checks++;
        if (ld_gnt !== 1'b1 || st_gnt !== 1'b0 || mem_req !== 1'b1 || mem_we !== 1'b0 ||
            mem_addr !== 32'h100 || busy !== 1'b1) begin
            errors++;
            $display("FAIL load_grant: gnt=%b%b req=%b we=%b addr=%h busy=%b, want 10 1 0 100 1",
                     ld_gnt, st_gnt, mem_req, mem_we, mem_addr, busy);
        end
        ld_req = 1'b0; ld_pc = 32'hFFFF; ld_addr = 32'hFFFF;
        tick();
        checks++;
        if (ld_gnt !== 1'b0 || mem_req !== 1'b1 || mem_addr !== 32'h100) begin
            errors++;
            $display("FAIL load_wait: ld_gnt=%b mem_req=%b addr=%h, want 0 1 100", ld_gnt, mem_req, mem_addr);
        end
        mem_ack = 1'b1; mem_rdata = 32'hDEAD_BEEF;
        tick();
        checks++;
        if (ld_done !== 1'b1 || st_done !== 1'b0 || ld_data !== 32'hDEAD_BEEF ||
            ld_done_pc !== 32'h8 || mem_req !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL load_done: done=%b%b data=%h pc=%h req=%b busy=%b, want 10 deadbeef 8 0 0",
                     ld_done, st_done, ld_data, ld_done_pc, mem_req, busy);
        end
        mem_ack = 1'b0; mem_rdata = 32'h0;
        tick();
        checks++;
        if (ld_done !== 1'b0 || ld_data !== 32'hDEAD_BEEF || ld_done_pc !== 32'h8) begin
            errors++;
            $display("FAIL load_hold: ld_done=%b data=%h pc=%h, want 0 deadbeef 8", ld_done, ld_data, ld_done_pc);
        end
    endtask

    task automatic test_store();
        st_req = 1'b1; st_addr = 32'h200; st_data = 32'h55;
        tick();
        checks++;
        if (st_gnt !== 1'b1 || ld_gnt !== 1'b0) begin
            errors++;
            $display("FAIL store_grant: st_gnt=%b ld_gnt=%b, want 1 0", st_gnt, ld_gnt);
        end
        st_req = 1'b0; st_addr = 32'h0; st_data = 32'h0;
        for (int c = 1; c <= 4; c++) begin
            if (c > 1) tick();
            checks++;
            if (mem_req !== 1'b1 || mem_we !== 1'b1 || mem_wdata !== 32'h55 || mem_addr !== 32'h200) begin
                errors++;
                $display("FAIL store_stable[%0d]: req=%b we=%b wdata=%h addr=%h, want 1 1 55 200",
                         c, mem_req, mem_we, mem_wdata, mem_addr);
            end
        end
        mem_ack = 1'b1;
        tick();
        checks++;
        if (st_done !== 1'b1 || ld_done !== 1'b0 || mem_req !== 1'b0 || timeout_err !== 1'b0) begin
            errors++;
            $display("FAIL store_done: st_done=%b ld_done=%b req=%b tmo=%b, want 1 0 0 0",
                     st_done, ld_done, mem_req, timeout_err);
        end
        mem_ack = 1'b0;
        tick();
        checks++;
        if (st_done !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL store_after: st_done=%b busy=%b, want 0 0", st_done, busy);
        end
    endtask

    task automatic test_ack_at_limit();
        ld_req = 1'b1; ld_pc = 32'h10; ld_addr = 32'h180;
        tick();
        ld_req = 1'b0;
        repeat (4) tick();
        checks++;
        if (mem_req !== 1'b1 || ld_done !== 1'b0) begin
            errors++;
            $display("FAIL limit_wait: mem_req=%b ld_done=%b, want 1 0", mem_req, ld_done);
        end
        mem_ack = 1'b1; mem_rdata = 32'hCAFE_0001;
        tick();
        checks++;
        if (ld_done !== 1'b1 || ld_data !== 32'hCAFE_0001 || ld_done_pc !== 32'h10 || timeout_err !== 1'b0) begin
            errors++;
            $display("FAIL ack_at_limit: done=%b data=%h pc=%h tmo=%b, want 1 cafe0001 10 0",
                     ld_done, ld_data, ld_done_pc, timeout_err);
        end
        mem_ack = 1'b0; mem_rdata = 32'h0;
        tick();
    endtask

    task automatic test_contention();
        logic exp_ld_g, exp_st_g, exp_ld_d, exp_st_d, prev_ld;
        prev_ld = 1'b0;
        ld_req = 1'b1; ld_pc = 32'h40; ld_addr = 32'h300;
        st_req = 1'b1; st_addr = 32'h400; st_data = 32'h99;
        mem_ack = 1'b1; mem_rdata = 32'h1234_5678;
        for (int c = 1; c <= 8; c++) begin
            tick();
            exp_ld_g = 1'b0; exp_st_g = 1'b0; exp_ld_d = 1'b0; exp_st_d = 1'b0;
            if (c % 2 == 1) begin
`ifdef MEM_ARB_RR_EN
                prev_ld = (c == 1 || c == 5);
`else
                prev_ld = 1'b1;
`endif
                exp_ld_g = prev_ld;
                exp_st_g = !prev_ld;
            end else begin
                exp_ld_d = prev_ld;
                exp_st_d = !prev_ld;
            end
            checks++;
            if (ld_gnt !== exp_ld_g || st_gnt !== exp_st_g || ld_done !== exp_ld_d || st_done !== exp_st_d) begin
                errors++;
                $display("FAIL contention[%0d]: gnt=%b%b done=%b%b, want gnt=%b%b done=%b%b",
                         c, ld_gnt, st_gnt, ld_done, st_done, exp_ld_g, exp_st_g, exp_ld_d, exp_st_d);
            end
            if (c % 2 == 1) begin
                checks++;
                if (mem_addr !== (prev_ld ? 32'h300 : 32'h400) || mem_we !== !prev_ld) begin
                    errors++;
                    $display("FAIL contention_payload[%0d]: addr=%h we=%b, want %h %b",
                             c, mem_addr, mem_we, prev_ld ? 32'h300 : 32'h400, !prev_ld);
                end
            end
        end
        ld_req = 1'b0; st_req = 1'b0; mem_ack = 1'b0; mem_rdata = 32'h0;
        tick();
        checks++;
        if (busy !== 1'b0 || ld_data !== 32'h1234_5678 || ld_done_pc !== 32'h40) begin
            errors++;
            $display("FAIL contention_end: busy=%b data=%h pc=%h, want 0 12345678 40", busy, ld_data, ld_done_pc);
        end
    endtask

    task automatic test_timeout();
        ld_req = 1'b1; ld_pc = 32'h20; ld_addr = 32'h500;
        tick();
        ld_req = 1'b0;
        for (int c = 1; c <= 5; c++) begin
            if (c > 1) tick();
            checks++;
            if (mem_req !== 1'b1 || timeout_err !== 1'b0) begin
                errors++;
                $display("FAIL timeout_wait[%0d]: mem_req=%b tmo=%b, want 1 0", c, mem_req, timeout_err);
            end
        end
        tick();
        checks++;
        if (mem_req !== 1'b0 || ld_done !== 1'b1 || ld_data !== 32'h0 || ld_done_pc !== 32'h20 ||
            timeout_err !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL timeout_fire: req=%b done=%b data=%h pc=%h tmo=%b busy=%b, want 0 1 0 20 1 0",
                     mem_req, ld_done, ld_data, ld_done_pc, timeout_err, busy);
        end
        repeat (10) tick();
        checks++;
        if (timeout_err !== 1'b1 || ld_done !== 1'b0) begin
            errors++;
            $display("FAIL timeout_sticky: tmo=%b ld_done=%b, want 1 0", timeout_err, ld_done);
        end
    endtask

    task automatic test_reset_mid_wait();
        ld_req = 1'b1; ld_pc = 32'h30; ld_addr = 32'h580;
        tick();
        ld_req = 1'b0;
        tick();
        #2 rstn = 1'b0;
        #1;
        checks++;
        if (mem_req !== 1'b0 || busy !== 1'b0 || timeout_err !== 1'b0 || ld_done_pc !== 32'h0 || mem_addr !== 32'h0) begin
            errors++;
            $display("FAIL async_reset: req=%b busy=%b tmo=%b pc=%h addr=%h, want 0 0 0 0 0",
                     mem_req, busy, timeout_err, ld_done_pc, mem_addr);
        end
        tick();
        #3 rstn = 1'b1;
        tick();
        checks++;
        if (ld_done !== 1'b0 || st_done !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_no_done: ld_done=%b st_done=%b busy=%b, want 0 0 0", ld_done, st_done, busy);
        end
        ld_req = 1'b1; ld_pc = 32'h34; ld_addr = 32'h600;
        tick();
        checks++;
        if (ld_gnt !== 1'b1 || mem_req !== 1'b1 || mem_addr !== 32'h600) begin
            errors++;
            $display("FAIL post_reset_gnt: gnt=%b req=%b addr=%h, want 1 1 600", ld_gnt, mem_req, mem_addr);
        end
        ld_req = 1'b0; mem_ack = 1'b1; mem_rdata = 32'h77;
        tick();
        checks++;
        if (ld_done !== 1'b1 || ld_data !== 32'h77 || ld_done_pc !== 32'h34) begin
            errors++;
            $display("FAIL post_reset_done: done=%b data=%h pc=%h, want 1 77 34", ld_done, ld_data, ld_done_pc);
        end
        mem_ack = 1'b0; mem_rdata = 32'h0;
        tick();
    endtask

    // Grants and completions are mutually exclusive on every edge.
    always @(negedge clk) begin
        if (rstn === 1'b1 && ((ld_gnt && st_gnt) || (ld_done && st_done))) begin
            checks++;
            errors++;
            $display("FAIL exclusive: gnt=%b%b done=%b%b, want never both", ld_gnt, st_gnt, ld_done, st_done);
        end
    end

    initial begin
        test_reset();
        test_load();
        test_store();
        test_ack_at_limit();
        test_contention();
        test_timeout();
        test_reset_mid_wait();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, memory address width.
REQ-002 SHALL have parameter DATA_W, default 32, memory data width.
REQ-003 SHALL have parameter MAX_WAIT, default 15, cycles to wait for mem_ack before timeout; legal range 1..255.
REQ-004 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-005 SHALL have port rstn  input  1  asynchronous, active-low reset.
REQ-006 SHALL have ports ld_req input 1, ld_pc input 32, ld_addr input ADDR_W: load request from the LSQ issue stage.
REQ-007 SHALL have ports ld_gnt output 1, ld_done output 1, ld_done_pc output 32, ld_data output DATA_W: load accept pulse and load completion.
REQ-008 SHALL have ports st_req input 1, st_addr input ADDR_W, st_data input DATA_W: retired-store drain request.
REQ-009 SHALL have ports st_gnt output 1 and st_done output 1: store accept pulse and store write completion.
REQ-010 SHALL have ports mem_req output 1, mem_we output 1, mem_addr output ADDR_W, mem_wdata output DATA_W, mem_ack input 1, mem_rdata input DATA_W: single data-memory port.
REQ-011 SHALL have ports busy output 1 (state != IDLE) and timeout_err output 1 (sticky timeout flag).

Function
REQ-012 SHALL implement a two-state FSM: IDLE and WAIT.
REQ-013 In IDLE with any request pending, SHALL on the next edge latch the winner's payload, pulse its gnt for exactly one cycle, drive mem_req=1 with mem_we=1 for a store and 0 for a load, and enter WAIT.
REQ-014 Requesters hold req and payload stable until gnt is sampled high. The arbiter SHALL ignore all req inputs while in WAIT and during the gnt cycle.
REQ-015 mem_req, mem_we, mem_addr and mem_wdata SHALL stay constant in WAIT until mem_ack is sampled high.
REQ-016 On mem_ack in WAIT, SHALL on the next edge deassert mem_req and return to IDLE.
REQ-017 On that same edge, a load SHALL pulse ld_done for one cycle, with ld_data = the mem_rdata sampled with mem_ack and ld_done_pc = the latched ld_pc.
REQ-018 On that same edge, a store SHALL pulse st_done for one cycle.
REQ-019 ld_data and ld_done_pc SHALL hold their values until the next load completion.
REQ-020 Minimum spacing between gnts SHALL be 2 cycles: with mem_ack tied high, gnt at cycle N gives done and IDLE at N+1 and the next gnt at N+2.
REQ-021 mem_ack sampled outside WAIT SHALL be ignored.
REQ-022 A wait counter SHALL clear on entry to WAIT and increment each WAIT cycle without mem_ack.
REQ-023 When the wait counter reaches MAX_WAIT, SHALL on the next edge drop mem_req, return to IDLE, set timeout_err, and pulse the owner's done. For a load, ld_data = 0.
REQ-024 mem_ack in the same cycle the counter hits MAX_WAIT SHALL take precedence: normal completion, no timeout.
REQ-025 timeout_err SHALL remain set until reset.
REQ-026 ld_gnt and st_gnt SHALL never be high in the same cycle. ld_done and st_done SHALL never be high in the same cycle.

Reset
REQ-027 rstn low SHALL immediately, without a clock edge, force IDLE and clear the wait counter, arbitration history, and all outputs to 0, including timeout_err, ld_data and ld_done_pc.
REQ-028 Reset during WAIT SHALL abandon the transaction with no done pulse.
REQ-029 The first gnt after reset release SHALL occur no earlier than the first rising edge with rstn high.

Configuration
REQ-030 Macro MEM_ARB_RR_EN defined: a last-grant register SHALL alternate grants when ld_req and st_req are both pending in IDLE. The first contention after reset goes to the load.
REQ-031 Macro MEM_ARB_RR_EN undefined: loads SHALL have fixed priority over stores, and no last-grant state SHALL be present.
REQ-032 In both configurations, a lone pending request SHALL be granted on the next edge.

Verification
REQ-033 Load only, ld_pc=0x8, ld_addr=0x100, mem_ack one cycle after mem_req, mem_rdata=0xDEADBEEF -> one ld_gnt pulse, mem_we=0, mem_addr=0x100, then ld_done with ld_data=0xDEADBEEF and ld_done_pc=0x8.
REQ-034 Store only, st_addr=0x200, st_data=0x55, mem_ack after 3 cycles -> mem_we=1 and mem_wdata=0x55 held stable for 4 cycles, one st_done pulse, busy low afterwards.
REQ-035 ld_req and st_req both held continuously, mem_ack tied high -> with MEM_ARB_RR_EN: grants L,S,L,S at 2-cycle spacing; without it: L,L,L with no st_gnt.
REQ-036 MAX_WAIT=4, load issued, mem_ack never asserted -> mem_req high 5 cycles, then dropped, ld_done with ld_data=0, timeout_err=1 and still 1 ten cycles later.
REQ-037 rstn pulsed low mid-WAIT -> mem_req, busy and timeout_err drop asynchronously, no done pulse. After release, a new ld_req is granted normally.
